// File: rtl/store_monitor_if.sv
// Store-monitor bus: core store strobe, log read port and verdict status.
// The core/host side drives through master, the monitor answers through slave.
interface store_monitor_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_adr;
    logic [31:0] rd_data;
    logic        rd_empty;
    logic        overflow;
    logic [15:0] store_count;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic        done;

    modport master (
        output MemWrite, DataAdr, WriteData, rd_en,
        input  rd_valid, rd_adr, rd_data, rd_empty, overflow,
        input  store_count, pass, fail, timeout, done
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, rd_en,
        output rd_valid, rd_adr, rd_data, rd_empty, overflow,
        output store_count, pass, fail, timeout, done
    );
endinterface

// File: rtl/store_monitor.sv
// Data-bus store monitor: pass/fail/timeout verdict on the core's store stream.
// Define STORE_MON_LOG_EN to build the store log FIFO and overflow flag.
module store_monitor #(
    parameter logic [31:0] PASS_ADDR    = 32'd100,
    parameter logic [31:0] PASS_DATA    = 32'd25,
    parameter logic [31:0] SCRATCH_ADDR = 32'd96,
    parameter int          DEPTH        = 8,
    parameter int          TIMEOUT      = 1024
) (
    input logic           clk,
    input logic           reset,
    store_monitor_if.slave bus
);
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] PASS = 2'd1;
    localparam logic [1:0] FAIL = 2'd2;
    localparam logic [1:0] TMO  = 2'd3;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CYC = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [1:0]    stateNext;
    logic [CW-1:0] cycCnt;
    logic [15:0]   storeCount;
    logic          isRun;
    logic          storeSeen;
    logic          passHit;
    logic          failHit;
    logic          tmoHit;

    assign isRun     = (state == RUN);
    assign storeSeen = isRun && bus.MemWrite;
    assign passHit   = storeSeen && (bus.DataAdr == PASS_ADDR)
                     && (bus.WriteData == PASS_DATA);
    assign failHit   = storeSeen && !passHit
                     && (bus.DataAdr != SCRATCH_ADDR);
    // A verdict store on the last RUN cycle beats the timeout.
    assign tmoHit    = isRun && (cycCnt == LAST_CYC)
                     && !passHit && !failHit;

    always_comb begin
        stateNext = state;
        unique case (1'b1)
            passHit: stateNext = PASS;
            failHit: stateNext = FAIL;
            tmoHit:  stateNext = TMO;
            default: stateNext = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            cycCnt     <= '0;
            storeCount <= '0;
        end else begin
            state <= stateNext;
            if (isRun)
                cycCnt <= cycCnt + CW'(1);
            if (storeSeen && storeCount != 16'hFFFF)
                storeCount <= storeCount + 16'd1;
        end
    end

    assign bus.store_count = storeCount;
    assign bus.pass        = (state == PASS);
    assign bus.fail        = (state == FAIL);
    assign bus.timeout     = (state == TMO);
    assign bus.done        = (state != RUN);

`ifdef STORE_MON_LOG_EN
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          doPush;
    logic          rdValid;
    logic [31:0]   rdAdr;
    logic [31:0]   rdData;
    logic          ovf;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW])
                  && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign pop    = bus.rd_en && !empty;
    // A pop frees the slot the push lands in on the same edge.
    assign doPush = storeSeen && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            rdValid <= 1'b0;
            rdAdr   <= '0;
            rdData  <= '0;
            ovf     <= 1'b0;
        end else begin
            rdValid <= pop;
            if (pop) begin
                {rdAdr, rdData} <= mem[rdPtr[AW-1:0]];
                rdPtr <= rdPtr + PW'(1);
            end
            if (doPush) begin
                mem[wrPtr[AW-1:0]] <= {bus.DataAdr, bus.WriteData};
                wrPtr <= wrPtr + PW'(1);
            end
            if (storeSeen && !doPush)
                ovf <= 1'b1;
        end
    end

    assign bus.rd_valid = rdValid;
    assign bus.rd_adr   = rdAdr;
    assign bus.rd_data  = rdData;
    assign bus.rd_empty = empty;
    assign bus.overflow = ovf;
`else
    logic unusedRdEn;
    assign unusedRdEn   = bus.rd_en;
    assign bus.rd_valid = 1'b0;
    assign bus.rd_adr   = '0;
    assign bus.rd_data  = '0;
    assign bus.rd_empty = 1'b1;
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor (DEPTH=4, TIMEOUT=20).
// Log checks follow STORE_MON_LOG_EN; constant outputs are checked otherwise.
module tb_store_monitor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    store_monitor_if bus ();

    store_monitor #(
        .PASS_ADDR    (32'd100),
        .PASS_DATA    (32'd25),
        .SCRATCH_ADDR (32'd96),
        .DEPTH        (4),
        .TIMEOUT      (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic doReset();
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;
        bus.rd_en     = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = a;
        bus.WriteData = d;
        @(negedge clk);
        bus.MemWrite  = 1'b0;
    endtask

    task automatic test_reset();
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;
        bus.rd_en     = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.pass, bus.fail, bus.timeout, bus.done, bus.rd_valid,
             bus.overflow, bus.rd_empty} !== 7'b0000001)
            $display("FAIL reset_flags: got %b want 0000001",
                     {bus.pass, bus.fail, bus.timeout, bus.done,
                      bus.rd_valid, bus.overflow, bus.rd_empty});
        else passed++;
        checks++;
        if (bus.store_count !== 16'd0)
            $display("FAIL reset_count: got %0d want 0", bus.store_count);
        else passed++;
        checks++;
        if ({bus.rd_adr, bus.rd_data} !== 64'd0)
            $display("FAIL reset_rd: got %h want 0", {bus.rd_adr, bus.rd_data});
        else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_pass();
        logic [31:0] expAdr [3] = '{32'd96, 32'd96, 32'd100};
        logic [31:0] expDat [3] = '{32'd7, 32'd11, 32'd25};
        doReset();
        store(32'd96, 32'd7);
        store(32'd96, 32'd11);
        checks++;
        if (bus.done !== 1'b0)
            $display("FAIL pass_early: got done=%b want 0", bus.done);
        else passed++;
        store(32'd100, 32'd25);
        checks++;
        if ({bus.pass, bus.fail, bus.timeout, bus.done} !== 4'b1001)
            $display("FAIL pass_verdict: got %b want 1001",
                     {bus.pass, bus.fail, bus.timeout, bus.done});
        else passed++;
        checks++;
        if (bus.store_count !== 16'd3)
            $display("FAIL pass_count: got %0d want 3", bus.store_count);
        else passed++;
`ifdef STORE_MON_LOG_EN
        checks++;
        if (bus.rd_empty !== 1'b0)
            $display("FAIL pass_notempty: got %b want 0", bus.rd_empty);
        else passed++;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rd_valid, bus.rd_adr, bus.rd_data}
                !== {1'b1, expAdr[i], expDat[i]})
                $display("FAIL pass_pop%0d: got v=%b %0d,%0d want 1 %0d,%0d",
                         i, bus.rd_valid, bus.rd_adr, bus.rd_data,
                         expAdr[i], expDat[i]);
            else passed++;
        end
        bus.rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.rd_valid, bus.rd_empty, bus.rd_adr} !== {2'b01, 32'd100})
            $display("FAIL pass_drained: got v=%b e=%b adr=%0d want 0 1 100",
                     bus.rd_valid, bus.rd_empty, bus.rd_adr);
        else passed++;
`else
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rd_valid, bus.rd_empty, bus.rd_data} !== {2'b01, 32'd0})
                $display("FAIL pass_nolog%0d: got v=%b e=%b d=%0d want 0 1 0",
                         i, bus.rd_valid, bus.rd_empty, bus.rd_data);
            else passed++;
        end
        bus.rd_en = 1'b0;
        expAdr[0] = expDat[0];
`endif
    endtask

    task automatic test_fail();
        doReset();
        store(32'd100, 32'd24);
        checks++;
        if ({bus.pass, bus.fail, bus.done} !== 3'b011)
            $display("FAIL fail_verdict: got %b want 011",
                     {bus.pass, bus.fail, bus.done});
        else passed++;
        store(32'd100, 32'd25);
        checks++;
        if ({bus.pass, bus.fail, bus.timeout} !== 3'b010)
            $display("FAIL fail_sticky: got %b want 010",
                     {bus.pass, bus.fail, bus.timeout});
        else passed++;
        checks++;
        if (bus.store_count !== 16'd1)
            $display("FAIL fail_count: got %0d want 1", bus.store_count);
        else passed++;
`ifdef STORE_MON_LOG_EN
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'd24})
            $display("FAIL fail_log: got v=%b d=%0d want 1 24",
                     bus.rd_valid, bus.rd_data);
        else passed++;
        @(negedge clk);
        checks++;
        if ({bus.rd_valid, bus.rd_empty} !== 2'b01)
            $display("FAIL fail_log_end: got v=%b e=%b want 0 1",
                     bus.rd_valid, bus.rd_empty);
        else passed++;
`endif
        doReset();
        store(32'd96, 32'd1);
        store(32'd8, 32'd25);
        checks++;
        if ({bus.pass, bus.fail, bus.store_count} !== {2'b01, 16'd2})
            $display("FAIL fail_addr: got p=%b f=%b n=%0d want 0 1 2",
                     bus.pass, bus.fail, bus.store_count);
        else passed++;
    endtask

    task automatic test_timeout();
        doReset();
        repeat (19) @(negedge clk);
        checks++;
        if (bus.timeout !== 1'b0)
            $display("FAIL tmo_early: got %b want 0 after 19 edges", bus.timeout);
        else passed++;
        @(negedge clk);
        checks++;
        if ({bus.timeout, bus.done, bus.pass, bus.fail} !== 4'b1100)
            $display("FAIL tmo_edge20: got %b want 1100",
                     {bus.timeout, bus.done, bus.pass, bus.fail});
        else passed++;
        store(32'd100, 32'd25);
        checks++;
        if ({bus.pass, bus.timeout, bus.store_count} !== {2'b01, 16'd0})
            $display("FAIL tmo_ignore: got p=%b t=%b n=%0d want 0 1 0",
                     bus.pass, bus.timeout, bus.store_count);
        else passed++;

        doReset();
        repeat (19) @(negedge clk);
        store(32'd100, 32'd25);
        checks++;
        if ({bus.pass, bus.fail, bus.timeout} !== 3'b100)
            $display("FAIL tmo_pass_prio: got %b want 100",
                     {bus.pass, bus.fail, bus.timeout});
        else passed++;

        doReset();
        repeat (19) @(negedge clk);
        store(32'd100, 32'd24);
        checks++;
        if ({bus.pass, bus.fail, bus.timeout} !== 3'b010)
            $display("FAIL tmo_fail_prio: got %b want 010",
                     {bus.pass, bus.fail, bus.timeout});
        else passed++;

        doReset();
        repeat (19) @(negedge clk);
        store(32'd96, 32'd3);
        checks++;
        if ({bus.timeout, bus.store_count} !== {1'b1, 16'd1})
            $display("FAIL tmo_scratch: got t=%b n=%0d want 1 1",
                     bus.timeout, bus.store_count);
        else passed++;
    endtask

    task automatic test_back_to_back();
        doReset();
        bus.MemWrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.DataAdr   = 32'd96;
            bus.WriteData = 32'(i);
            @(negedge clk);
        end
        bus.MemWrite = 1'b0;
        checks++;
        if (bus.store_count !== 16'd5)
            $display("FAIL b2b_count: got %0d want 5", bus.store_count);
        else passed++;
`ifdef STORE_MON_LOG_EN
        checks++;
        if (bus.overflow !== 1'b1)
            $display("FAIL ovf_set: got %b want 1", bus.overflow);
        else passed++;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'(i)})
                $display("FAIL ovf_pop%0d: got v=%b d=%0d want 1 %0d",
                         i, bus.rd_valid, bus.rd_data, i);
            else passed++;
        end
        @(negedge clk);
        bus.rd_en = 1'b0;
        checks++;
        if ({bus.rd_valid, bus.rd_empty, bus.overflow} !== 3'b011)
            $display("FAIL ovf_empty_pop: got v=%b e=%b o=%b want 0 1 1",
                     bus.rd_valid, bus.rd_empty, bus.overflow);
        else passed++;

        doReset();
        bus.MemWrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.DataAdr   = 32'd96;
            bus.WriteData = 32'(i);
            if (i == 4) bus.rd_en = 1'b1;
            @(negedge clk);
        end
        bus.MemWrite = 1'b0;
        checks++;
        if ({bus.overflow, bus.rd_valid, bus.rd_data} !== {2'b01, 32'd0})
            $display("FAIL full_pop: got o=%b v=%b d=%0d want 0 1 0",
                     bus.overflow, bus.rd_valid, bus.rd_data);
        else passed++;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'(i)})
                $display("FAIL full_drain%0d: got v=%b d=%0d want 1 %0d",
                         i, bus.rd_valid, bus.rd_data, i);
            else passed++;
        end
        bus.rd_en = 1'b0;
        checks++;
        if ({bus.rd_empty, bus.overflow} !== 2'b10)
            $display("FAIL full_end: got e=%b o=%b want 1 0",
                     bus.rd_empty, bus.overflow);
        else passed++;
`else
        checks++;
        if ({bus.overflow, bus.rd_empty} !== 2'b01)
            $display("FAIL b2b_nolog: got o=%b e=%b want 0 1",
                     bus.overflow, bus.rd_empty);
        else passed++;
`endif
    endtask

    task automatic test_reset_midrun();
        doReset();
        store(32'd96, 32'd1);
        store(32'd96, 32'd2);
        store(32'd96, 32'd3);
        checks++;
        if (bus.store_count !== 16'd3)
            $display("FAIL mid_count: got %0d want 3", bus.store_count);
        else passed++;
`ifdef STORE_MON_LOG_EN
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'd1})
            $display("FAIL mid_pop: got v=%b d=%0d want 1 1",
                     bus.rd_valid, bus.rd_data);
        else passed++;
`endif
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.pass, bus.fail, bus.timeout, bus.done, bus.rd_valid,
             bus.overflow, bus.rd_empty} !== 7'b0000001)
            $display("FAIL mid_flags: got %b want 0000001",
                     {bus.pass, bus.fail, bus.timeout, bus.done,
                      bus.rd_valid, bus.overflow, bus.rd_empty});
        else passed++;
        checks++;
        if ({bus.store_count, bus.rd_adr, bus.rd_data} !== 80'd0)
            $display("FAIL mid_clear: got n=%0d adr=%0d d=%0d want 0 0 0",
                     bus.store_count, bus.rd_adr, bus.rd_data);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        store(32'd100, 32'd25);
        checks++;
        if ({bus.pass, bus.store_count} !== {1'b1, 16'd1})
            $display("FAIL mid_run: got p=%b n=%0d want 1 1",
                     bus.pass, bus.store_count);
        else passed++;
`ifdef STORE_MON_LOG_EN
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        checks++;
        if ({bus.rd_adr, bus.rd_data, bus.rd_empty}
            !== {32'd100, 32'd25, 1'b1})
            $display("FAIL mid_log: got %0d,%0d e=%b want 100,25 1",
                     bus.rd_adr, bus.rd_data, bus.rd_empty);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/store_monitor.md
# store_monitor

Synthesizable data-bus store monitor for the single-cycle RISC-V core on the FPGA board. It sits on the core's data-memory write interface alongside `top`'s `MemWrite`/`DataAdr`/`WriteData` outputs and judges the store stream. It decides pass, fail or timeout, and exposes the verdict as status outputs (for LEDs or a host). An optional log FIFO records each store, and the host drains it through a read port.

## Interface
Parameters:
- `PASS_ADDR`, default 32'd100: address whose store of `PASS_DATA` signals success.
- `PASS_DATA`, default 32'd25: required data for the pass store.
- `SCRATCH_ADDR`, default 32'd96: the only other address the program may store to.
- `DEPTH`, default 8: log FIFO entries; power of two, ≥2.
- `TIMEOUT`, default 1024: cycles in RUN before the timeout verdict; ≥1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemWrite` in 1: store strobe from the core.
- `DataAdr` in 32: store address.
- `WriteData` in 32: store data.
- `rd_en` in 1: log pop request.
- `rd_valid` out 1: `rd_adr` and `rd_data` hold a popped entry.
- `rd_adr` out 32: logged address.
- `rd_data` out 32: logged data.
- `rd_empty` out 1: log FIFO empty.
- `overflow` out 1: sticky flag; a store was dropped because the log was full.
- `store_count` out 16: stores accepted in RUN; saturates at 16'hFFFF.
- `pass`, `fail`, `timeout` out 1 each: verdict, one-hot or all zero.
- `done` out 1: equals `pass | fail | timeout`.

## Operation
- The FSM has four states: RUN, PASS, FAIL and TMO. Reset enters RUN.
- **RUN, on `MemWrite`=1:**
  - `DataAdr`==`PASS_ADDR` and `WriteData`==`PASS_DATA` → PASS.
  - Otherwise, `DataAdr`≠`SCRATCH_ADDR` → FAIL. This includes a store to `PASS_ADDR` with wrong data.
  - Otherwise → stay in RUN.
- **RUN, cycle counter:** counts every cycle spent in RUN. When it reaches `TIMEOUT-1` with no verdict store on that edge → TMO. A verdict store on the same edge takes priority over timeout.
- **Terminal states:** PASS, FAIL and TMO hold until `reset`. Stores seen in these states are ignored: not counted and not logged.
- **`store_count`:** increments on every `MemWrite` seen in RUN, including the store that causes the verdict.
- **Log FIFO:** pushes {`DataAdr`, `WriteData`} for every store counted by `store_count`.
  - Full with no pop that cycle: the push is dropped and `overflow` is set.
  - Full with a simultaneous pop: both the pop and the push are performed, and nothing is dropped.
  - `rd_en` while empty: ignored, and `rd_valid` is 0 the next cycle.
- **Pointers:** log2(`DEPTH`)+1 bits wide and wrap naturally. Full when the MSBs differ and the rest are equal.
- **Comparisons:** exact 32-bit equality. Inputs are sampled only when `MemWrite`=1.

## Timing
- **Reset values:** all outputs are 0, except `rd_empty`=1. The FSM is in RUN, and the counters and pointers are 0.
- **Verdict latency:** the verdict outputs assert one cycle after the deciding store, i.e. registered on the edge that samples `MemWrite`.
- **Timeout:** `timeout` asserts exactly `TIMEOUT` edges after reset deassertion, if no verdict occurs first.
- **Read latency:** 1 cycle. A pop on edge N makes `rd_valid`=1 with the data after edge N. `rd_valid` is high for one cycle per pop. `rd_adr`/`rd_data` hold their last value when `rd_valid`=0.
- **`rd_empty`:** combinational from the pointers. It updates after the edge that performs a push or pop.
- **Reset mid-run:** asserting `reset` asynchronously clears the state, the FIFO contents pointers, `overflow` and the counters in the same instant.
- **Back-to-back:** one store per cycle is sustained; `MemWrite` may stay high for consecutive cycles.

## Configuration
- **`STORE_MON_LOG_EN` defined:** the log FIFO and `overflow` logic are built as described above.
- **`STORE_MON_LOG_EN` undefined:**
  - The FIFO is omitted.
  - `rd_valid`=0, `rd_adr`=0, `rd_data`=0, `rd_empty`=1 and `overflow`=0, as constants.
  - `rd_en` is ignored.
  - The verdict FSM, `store_count` and the timeout behave identically.

## Test plan
- **Pass:** stores (96,7), (96,11), (100,25) → `pass`=1 and `done`=1 one cycle after the third store; `store_count`=3; log pops return the three pairs in order.
- **Fail:** store (100,24) → `fail`=1; a later (100,25) leaves `fail`=1 and `pass`=0, and `store_count` stays 1.
- **Timeout:** `TIMEOUT`=20, no stores → `timeout`=1 exactly 20 edges after reset release; a verdict store on edge 20 yields `pass`/`fail` instead.
- **Overflow:** `DEPTH`=4, five (96,i) stores with no pops → `overflow`=1; pops return i=0..3, then `rd_empty`=1. Repeat with `rd_en` held on the fifth store → no overflow, and all five entries are drained.
- **Reset mid-run:** three (96,x) stores, then `reset`=0 for 1 cycle → all outputs return to reset values immediately, the FSM is in RUN, and the log is empty.
- **Macro off:** build without `STORE_MON_LOG_EN` and run the pass scenario → `pass`=1, `store_count`=3, `rd_valid` never 1, `rd_empty` constantly 1.
